uart_tx_arbiter: RTL and testbench

Shares the single uart_send transmitter between N message sources. Arbitration is round-robin at message granularity: the winning requester keeps the channel until it has sent its byte flagged "last", or until it times out. The block paces bytes by counting the UART frame time, because uart_send has no ready/busy output. It sits between the message-producing FSMs and the uart_send instance in top.

---
 rtl/uart_tx_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter in front of a uart_send that has no ready output.
// Bytes are paced by counting the UART frame time; an idle owner is revoked after HOLD_MAX cycles.
module uart_tx_arbiter #(
    parameter int unsigned N           = 4,
    parameter int unsigned CHAR_CYCLES = 104160,
    parameter int unsigned GAP_CYCLES  = 0,
    parameter int unsigned HOLD_MAX    = 1000000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] data,
    input  logic [N-1:0]   last,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   drop,
    output logic           busy,
    output logic [7:0]     uart_data,
    output logic           uart_valid
);

    localparam int unsigned MaxA   = (CHAR_CYCLES > GAP_CYCLES) ? CHAR_CYCLES : GAP_CYCLES;
    localparam int unsigned MaxCyc = (MaxA > HOLD_MAX) ? MaxA : HOLD_MAX;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
    localparam int unsigned IdxW   = $clog2(N);

    localparam logic [CntW-1:0] CharLast = CntW'(CHAR_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_MAX - 1);
    localparam logic [CntW-1:0] GapLast  = (GAP_CYCLES > 0) ? CntW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {StIdle, StSend, StWait, StHold, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] prev_owner_q, prev_owner_d;
    logic            last_q, last_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [N-1:0]    ack_q, ack_d;
    logic [N-1:0]    drop_q, drop_d;
    logic            busy_q, busy_d;
    logic [7:0]      uart_data_q, uart_data_d;
    logic            uart_valid_q, uart_valid_d;

    logic            found;
    logic [IdxW-1:0] sel;
    logic [IdxW-1:0] idx;
    logic [7:0]      owner_byte;

    // Search starts just past the previous owner so every other requester is served first.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IdxW'((32'(prev_owner_q) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        owner_byte = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (owner_q == IdxW'(i)) begin
                owner_byte = data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        prev_owner_d = prev_owner_q;
        last_d       = last_q;
        grant_d      = grant_q;
        ack_d        = '0;
        drop_d       = '0;
        uart_data_d  = uart_data_q;
        uart_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    owner_d      = sel;
                    prev_owner_d = sel;
                    state_d      = StSend;
                end
            end
            StSend: begin
                uart_data_d    = owner_byte;
                uart_valid_d   = 1'b1;
                ack_d[owner_q] = 1'b1;
                last_d         = last[owner_q];
                cnt_d          = '0;
                state_d        = StWait;
            end
            StWait: begin
                if (cnt_q == CharLast) begin
                    cnt_d = '0;
                    if (last_q) begin
                        grant_d = '0;
                        state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
                    end else if (req[owner_q]) begin
                        state_d = StSend;
                    end else begin
                        state_d = StHold;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (req[owner_q]) begin
                    state_d = StSend;
                end else if (cnt_q == HoldLast) begin
                    drop_d[owner_q] = 1'b1;
                    grant_d         = '0;
                    cnt_d           = '0;
                    state_d         = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            owner_q      <= '0;
            prev_owner_q <= IdxW'(N - 1);
            last_q       <= 1'b0;
            grant_q      <= '0;
            ack_q        <= '0;
            drop_q       <= '0;
            busy_q       <= 1'b0;
            uart_data_q  <= '0;
            uart_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            prev_owner_q <= prev_owner_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            drop_q       <= drop_d;
            busy_q       <= busy_d;
            uart_data_q  <= uart_data_d;
            uart_valid_q <= uart_valid_d;
        end
    end

    assign ack        = ack_q;
    assign grant      = grant_q;
    assign drop       = drop_q;
    assign busy       = busy_q;
    assign uart_data  = uart_data_q;
    assign uart_valid = uart_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with CHAR_CYCLES=10, GAP_CYCLES=3, HOLD_MAX=20, N=4.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [3:0]  drop;
    logic        busy;
    logic [7:0]  uart_data;
    logic        uart_valid;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N           (4),
        .CHAR_CYCLES (10),
        .GAP_CYCLES  (3),
        .HOLD_MAX    (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data       (data),
        .last       (last),
        .ack        (ack),
        .grant      (grant),
        .drop       (drop),
        .busy       (busy),
        .uart_data  (uart_data),
        .uart_valid (uart_valid)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; last = '0; data = '0;
        tick(2);
        checks++; if (grant !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", grant); else passed++;
        checks++; if (ack !== 4'b0000) $display("FAIL rst_ack: got %b want 0000", ack); else passed++;
        checks++; if (drop !== 4'b0000) $display("FAIL rst_drop: got %b want 0000", drop); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        checks++; if (uart_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", uart_valid); else passed++;
        checks++; if (uart_data !== 8'h00) $display("FAIL rst_data: got %h want 00", uart_data); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single_message;
        data[7:0] = 8'h68; last[0] = 1'b0; req[0] = 1'b1;
        tick(1);
        checks++; if (grant !== 4'b0001) $display("FAIL t1_grant: got %b want 0001", grant); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL t1_busy: got %b want 1", busy); else passed++;
        tick(1);
        checks++; if (uart_valid !== 1'b1) $display("FAIL t1_valid0: got %b want 1", uart_valid); else passed++;
        checks++; if (uart_data !== 8'h68) $display("FAIL t1_data0: got %h want 68", uart_data); else passed++;
        checks++; if (ack !== 4'b0001) $display("FAIL t1_ack0: got %b want 0001", ack); else passed++;
        data[7:0] = 8'h69;
        tick(1);
        checks++; if (uart_valid !== 1'b0) $display("FAIL t1_pulse: got %b want 0", uart_valid); else passed++;
        checks++; if (ack !== 4'b0000) $display("FAIL t1_ackpulse: got %b want 0000", ack); else passed++;
        tick(10);
        checks++; if (uart_valid !== 1'b1) $display("FAIL t1_valid1: got %b want 1", uart_valid); else passed++;
        checks++; if (uart_data !== 8'h69) $display("FAIL t1_data1: got %h want 69", uart_data); else passed++;
        checks++; if (ack !== 4'b0001) $display("FAIL t1_ack1: got %b want 0001", ack); else passed++;
        checks++; if (grant !== 4'b0001) $display("FAIL t1_grant1: got %b want 0001", grant); else passed++;
        data[7:0] = 8'h74; last[0] = 1'b1;
        tick(11);
        checks++; if (uart_valid !== 1'b1) $display("FAIL t1_valid2: got %b want 1", uart_valid); else passed++;
        checks++; if (uart_data !== 8'h74) $display("FAIL t1_data2: got %h want 74", uart_data); else passed++;
        checks++; if (ack !== 4'b0001) $display("FAIL t1_ack2: got %b want 0001", ack); else passed++;
        req[0] = 1'b0;
        tick(9);
        checks++; if (grant !== 4'b0001) $display("FAIL t1_grant_end: got %b want 0001", grant); else passed++;
        tick(1);
        checks++; if (grant !== 4'b0000) $display("FAIL t1_grant_gap: got %b want 0000", grant); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL t1_busy_gap: got %b want 1", busy); else passed++;
        tick(2);
        checks++; if (busy !== 1'b1) $display("FAIL t1_busy_gap3: got %b want 1", busy); else passed++;
        tick(1);
        checks++; if (busy !== 1'b0) $display("FAIL t1_idle: got %b want 0", busy); else passed++;
    endtask

    task automatic test_all_request;
        logic [3:0] oh;
        logic [7:0] exp_byte;
        rst = 1'b1;
        tick(1);
        rst = 1'b0; req = 4'b1111; last = 4'b1111; data = 32'hA3A2A1A0;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            exp_byte = 8'hA0 + 8'(k);
            checks++; if (grant !== oh) $display("FAIL t2_grant%0d: got %b want %b", k, grant, oh); else passed++;
            tick(1);
            checks++; if (uart_valid !== 1'b1) $display("FAIL t2_valid%0d: got %b want 1", k, uart_valid); else passed++;
            checks++; if (uart_data !== exp_byte) $display("FAIL t2_data%0d: got %h want %h", k, uart_data, exp_byte); else passed++;
            checks++; if (ack !== oh) $display("FAIL t2_ack%0d: got %b want %b", k, ack, oh); else passed++;
            req[k] = 1'b0;
            tick(5);
            checks++; if (grant !== oh) $display("FAIL t2_hold%0d: got %b want %b", k, grant, oh); else passed++;
            tick(9);
        end
        checks++; if (busy !== 1'b0) $display("FAIL t2_idle: got %b want 0", busy); else passed++;
        checks++; if (grant !== 4'b0000) $display("FAIL t2_free: got %b want 0000", grant); else passed++;
    endtask

    task automatic test_two_byte_owner;
        req = 4'b0100; data[23:16] = 8'hB0; last = 4'b0000;
        tick(1);
        checks++; if (grant !== 4'b0100) $display("FAIL t3_grant2: got %b want 0100", grant); else passed++;
        req[1] = 1'b1; data[15:8] = 8'h11; last[1] = 1'b1;
        tick(1);
        checks++; if (uart_data !== 8'hB0) $display("FAIL t3_data0: got %h want b0", uart_data); else passed++;
        checks++; if (ack !== 4'b0100) $display("FAIL t3_ack0: got %b want 0100", ack); else passed++;
        data[23:16] = 8'hB1; last[2] = 1'b1;
        tick(11);
        checks++; if (uart_valid !== 1'b1) $display("FAIL t3_valid1: got %b want 1", uart_valid); else passed++;
        checks++; if (uart_data !== 8'hB1) $display("FAIL t3_data1: got %h want b1", uart_data); else passed++;
        checks++; if (grant !== 4'b0100) $display("FAIL t3_grant_b1: got %b want 0100", grant); else passed++;
        req[2] = 1'b0;
        tick(7);
        checks++; if (grant !== 4'b0100) $display("FAIL t3_no_preempt: got %b want 0100", grant); else passed++;
        tick(7);
        checks++; if (grant !== 4'b0010) $display("FAIL t3_grant1: got %b want 0010", grant); else passed++;
        tick(1);
        checks++; if (uart_data !== 8'h11) $display("FAIL t3_data_r1: got %h want 11", uart_data); else passed++;
        checks++; if (ack !== 4'b0010) $display("FAIL t3_ack_r1: got %b want 0010", ack); else passed++;
        req[1] = 1'b0; req[2] = 1'b1; data[23:16] = 8'hB2;
        tick(14);
        checks++; if (grant !== 4'b0100) $display("FAIL t3_regrant2: got %b want 0100", grant); else passed++;
        tick(1);
        checks++; if (uart_data !== 8'hB2) $display("FAIL t3_data_b2: got %h want b2", uart_data); else passed++;
        req[3] = 1'b1; data[31:24] = 8'hC3; last[3] = 1'b1;
        tick(14);
        checks++; if (grant !== 4'b1000) $display("FAIL t3_rr3: got %b want 1000", grant); else passed++;
        tick(1);
        checks++; if (uart_data !== 8'hC3) $display("FAIL t3_data_c3: got %h want c3", uart_data); else passed++;
        checks++; if (ack !== 4'b1000) $display("FAIL t3_ack_c3: got %b want 1000", ack); else passed++;
        req[3] = 1'b0;
        tick(14);
        checks++; if (grant !== 4'b0100) $display("FAIL t3_lone2: got %b want 0100", grant); else passed++;
        tick(1);
        req[2] = 1'b0;
        tick(13);
        checks++; if (busy !== 1'b0) $display("FAIL t3_idle: got %b want 0", busy); else passed++;
    endtask

    task automatic test_hold_timeout;
        req = 4'b0001; data[7:0] = 8'h40; last = 4'b0000;
        tick(1);
        checks++; if (grant !== 4'b0001) $display("FAIL t4_grant0: got %b want 0001", grant); else passed++;
        req[3] = 1'b1; data[31:24] = 8'hD3; last[3] = 1'b1;
        tick(1);
        checks++; if (uart_data !== 8'h40) $display("FAIL t4_data0: got %h want 40", uart_data); else passed++;
        req[0] = 1'b0;
        tick(10);
        checks++; if (grant !== 4'b0001) $display("FAIL t4_hold_grant: got %b want 0001", grant); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL t4_hold_busy: got %b want 1", busy); else passed++;
        tick(19);
        checks++; if (drop !== 4'b0000) $display("FAIL t4_drop_early: got %b want 0000", drop); else passed++;
        checks++; if (grant !== 4'b0001) $display("FAIL t4_grant_late: got %b want 0001", grant); else passed++;
        tick(1);
        checks++; if (drop !== 4'b0001) $display("FAIL t4_drop: got %b want 0001", drop); else passed++;
        checks++; if (grant !== 4'b0000) $display("FAIL t4_revoked: got %b want 0000", grant); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL t4_idle: got %b want 0", busy); else passed++;
        tick(1);
        checks++; if (drop !== 4'b0000) $display("FAIL t4_drop_pulse: got %b want 0000", drop); else passed++;
        checks++; if (grant !== 4'b1000) $display("FAIL t4_grant3: got %b want 1000", grant); else passed++;
        tick(1);
        checks++; if (uart_data !== 8'hD3) $display("FAIL t4_data3: got %h want d3", uart_data); else passed++;
        checks++; if (ack !== 4'b1000) $display("FAIL t4_ack3: got %b want 1000", ack); else passed++;
        req[3] = 1'b0;
        tick(13);
        checks++; if (busy !== 1'b0) $display("FAIL t4_end: got %b want 0", busy); else passed++;
    endtask

    task automatic test_hold_resume;
        req = 4'b0001; data[7:0] = 8'h50; last = 4'b0000;
        tick(2);
        checks++; if (uart_data !== 8'h50) $display("FAIL t5_data0: got %h want 50", uart_data); else passed++;
        req[0] = 1'b0; data[7:0] = 8'h51; last[0] = 1'b1;
        tick(14);
        checks++; if (drop !== 4'b0000) $display("FAIL t5_drop_hold: got %b want 0000", drop); else passed++;
        req[0] = 1'b1;
        tick(1);
        checks++; if (grant !== 4'b0001) $display("FAIL t5_grant: got %b want 0001", grant); else passed++;
        checks++; if (uart_valid !== 1'b0) $display("FAIL t5_send_cyc: got %b want 0", uart_valid); else passed++;
        tick(1);
        checks++; if (uart_valid !== 1'b1) $display("FAIL t5_valid1: got %b want 1", uart_valid); else passed++;
        checks++; if (uart_data !== 8'h51) $display("FAIL t5_data1: got %h want 51", uart_data); else passed++;
        checks++; if (ack !== 4'b0001) $display("FAIL t5_ack1: got %b want 0001", ack); else passed++;
        checks++; if (drop !== 4'b0000) $display("FAIL t5_no_drop: got %b want 0000", drop); else passed++;
        req[0] = 1'b0;
        tick(13);
        checks++; if (busy !== 1'b0) $display("FAIL t5_end: got %b want 0", busy); else passed++;
    endtask

    task automatic test_reset_mid_byte;
        req = 4'b0001; data[7:0] = 8'h60; last = 4'b0001;
        tick(5);
        checks++; if (busy !== 1'b1) $display("FAIL t6_busy_wait: got %b want 1", busy); else passed++;
        rst = 1'b1; req = 4'b0011; data[15:8] = 8'h61; last[1] = 1'b1;
        tick(1);
        checks++; if (grant !== 4'b0000) $display("FAIL t6_grant: got %b want 0000", grant); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL t6_busy: got %b want 0", busy); else passed++;
        checks++; if (uart_valid !== 1'b0) $display("FAIL t6_valid: got %b want 0", uart_valid); else passed++;
        checks++; if (uart_data !== 8'h00) $display("FAIL t6_data: got %h want 00", uart_data); else passed++;
        checks++; if (ack !== 4'b0000) $display("FAIL t6_ack: got %b want 0000", ack); else passed++;
        checks++; if (drop !== 4'b0000) $display("FAIL t6_drop: got %b want 0000", drop); else passed++;
        rst = 1'b0;
        tick(1);
        checks++; if (grant !== 4'b0001) $display("FAIL t6_prio0: got %b want 0001", grant); else passed++;
        tick(1);
        checks++; if (uart_data !== 8'h60) $display("FAIL t6_data0: got %h want 60", uart_data); else passed++;
        checks++; if (ack !== 4'b0001) $display("FAIL t6_ack0: got %b want 0001", ack); else passed++;
        req = 4'b0000;
        tick(20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_message();
        test_all_request();
        test_two_byte_owner();
        test_hold_timeout();
        test_hold_resume();
        test_reset_mid_byte();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
